wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of writeback requesters, power of two in the range 2..8.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, NREQ: requester i holds a result.
REQ-005 SHALL have port req_robid, input, NREQ*7: ROB index per requester, slice [i*7+6:i*7].
REQ-006 SHALL have port req_result, input, NREQ*32: result per requester.
REQ-007 SHALL have port req_error, input, NREQ: exception flag per requester.
REQ-008 SHALL have port req_ecause, input, NREQ*5: exception cause per requester.
REQ-009 SHALL have port req_ready, output, NREQ: one-hot grant; the request is consumed in this cycle.
REQ-010 SHALL have port rob_flush, input, 1: pipeline flush from the retirement unit.
REQ-011 SHALL have ports wb_valid (1), wb_error (1), wb_ecause (5), wb_robid (7) and wb_result (32), all outputs: the single ROB writeback port.
REQ-012 SHALL have port wb_grant, output, log2(NREQ): index of the requester driving the wb port.

Function
REQ-013 SHALL keep a round-robin pointer ptr, width log2(NREQ).
- Winner = first i with req_valid[i], scanning ptr, ptr+1, ... with mod-NREQ wrap.
REQ-014 SHALL set req_ready to the one-hot of the winner in the same cycle (combinational).
- req_ready SHALL be all-zero when req_valid is all-zero.
REQ-015 SHALL never assert more than one req_ready bit in a cycle.
REQ-016 On any cycle with a winner w, ptr SHALL become (w+1) mod NREQ at the next edge; with no winner, ptr holds.
- Wrap example: w = NREQ-1 sets ptr to 0.
REQ-017 Requesters SHALL hold valid and payload stable until ready; the arbiter assumes this and does not check it.
REQ-018 The ROB port is never back-pressured, so exactly one request retires per cycle whenever any req_valid bit is set.
REQ-019 SHALL starve no requester: a continuously valid requester is granted within NREQ cycles.
REQ-020 While rob_flush=1, winner selection, req_ready and the ptr update SHALL proceed normally.
- The granted payload SHALL be discarded: wb_valid is not asserted for it.
REQ-021 wb_error, wb_ecause, wb_robid and wb_result SHALL carry the winner's fields when wb_valid=1; their value is don't-care when wb_valid=0.

Reset
REQ-022 On rst, ptr SHALL be 0 and wb_valid SHALL be 0.
- With WB_ARBITER_OUTREG_EN defined, the output register SHALL be cleared.
REQ-023 rst mid-stream SHALL drop any request in flight.
- The first grant after rst SHALL go to the lowest-index valid requester.
REQ-024 rst SHALL take precedence over rob_flush and over the ptr update.

Configuration
REQ-025 Macro WB_ARBITER_OUTREG_EN SHALL select the output timing.
- Undefined: wb_* is a combinational function of the winner, with wb_valid = any(req_valid) & ~rob_flush; latency 0.
- Defined: wb_* and wb_grant are registered; wb_valid(t+1) = any(req_valid(t)) & ~rob_flush(t); latency 1.
- Defined: rob_flush=1 SHALL also force wb_valid=0 in the same cycle, killing the registered entry.
- Arbitration and req_ready timing SHALL be identical in both builds.

Verification
REQ-026 Single requester: req_valid=0b0100, robid=0x15, result=0xDEADBEEF -> req_ready=0b0100, wb_valid=1, wb_robid=0x15, wb_result=0xDEADBEEF, wb_grant=2, at 0 or 1 cycle latency per build.
REQ-027 All four valid and held for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, with one wb_valid per cycle.
REQ-028 Wrap: ptr=3, req_valid=0b1001 -> grant 3, then grant 0; ptr ends at 1.
REQ-029 rob_flush=1 with req_valid=0b0010 -> req_ready=0b0010 and ptr advances to 2, but no wb_valid for that robid.
- OUTREG build: an entry registered in the previous cycle is also suppressed.
REQ-030 rst asserted while req_valid=0b1111 and ptr=2 -> next cycle ptr=0, wb_valid=0; the first grant after rst deasserts goes to requester 0.
REQ-031 Error path: req_error[1]=1, ecause=0x05 -> wb_error=1, wb_ecause=0x05 on requester 1's grant.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester-side handshake/payload plus the single ROB writeback port.
// The arbiter takes the slave view; requesters and the ROB side take the master view.
interface wb_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*7-1:0]  req_robid;
    logic [NREQ*32-1:0] req_result;
    logic [NREQ-1:0]    req_error;
    logic [NREQ*5-1:0]  req_ecause;
    logic [NREQ-1:0]    req_ready;
    logic               rob_flush;

    logic               wb_valid;
    logic               wb_error;
    logic [4:0]         wb_ecause;
    logic [6:0]         wb_robid;
    logic [31:0]        wb_result;
    logic [PW-1:0]      wb_grant;

    modport master (
        output req_valid, req_robid, req_result, req_error, req_ecause, rob_flush,
        input  req_ready, wb_valid, wb_error, wb_ecause, wb_robid, wb_result, wb_grant
    );

    modport slave (
        input  req_valid, req_robid, req_result, req_error, req_ecause, rob_flush,
        output req_ready, wb_valid, wb_error, wb_ecause, wb_robid, wb_result, wb_grant
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NREQ result producers share one ROB writeback port.
// Define WB_ARBITER_OUTREG_EN to register the wb_* outputs (latency 1); default is combinational.
module wb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] scan_idx;
    logic          win_found;
    logic          grant;

    logic [6:0]    robid_a  [NREQ];
    logic [31:0]   result_a [NREQ];
    logic [4:0]    ecause_a [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign robid_a[gi]  = bus.req_robid[gi*7 +: 7];
            assign result_a[gi] = bus.req_result[gi*32 +: 32];
            assign ecause_a[gi] = bus.req_ecause[gi*5 +: 5];
        end
    endgenerate

    // NREQ is a power of two, so the PW-bit add wraps modulo NREQ for free.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr + PW'(k);
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Nothing is consumed while in reset; requesters keep holding and are re-arbitrated from 0.
    assign grant         = win_found & ~rst;
    assign bus.req_ready = grant ? (NREQ'(1) << win_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (win_found) begin
            ptr <= win_idx + 1'b1;
        end
    end

`ifdef WB_ARBITER_OUTREG_EN
    logic          wb_valid_q;
    logic          wb_error_q;
    logic [4:0]    wb_ecause_q;
    logic [6:0]    wb_robid_q;
    logic [31:0]   wb_result_q;
    logic [PW-1:0] wb_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_error_q  <= 1'b0;
            wb_ecause_q <= '0;
            wb_robid_q  <= '0;
            wb_result_q <= '0;
            wb_grant_q  <= '0;
        end else begin
            wb_valid_q  <= win_found & ~bus.rob_flush;
            wb_error_q  <= bus.req_error[win_idx];
            wb_ecause_q <= ecause_a[win_idx];
            wb_robid_q  <= robid_a[win_idx];
            wb_result_q <= result_a[win_idx];
            wb_grant_q  <= win_idx;
        end
    end

    // A flush arriving one cycle after capture still kills the registered entry.
    assign bus.wb_valid  = wb_valid_q & ~bus.rob_flush & ~rst;
    assign bus.wb_error  = wb_error_q;
    assign bus.wb_ecause = wb_ecause_q;
    assign bus.wb_robid  = wb_robid_q;
    assign bus.wb_result = wb_result_q;
    assign bus.wb_grant  = wb_grant_q;
`else
    assign bus.wb_valid  = grant & ~bus.rob_flush;
    assign bus.wb_error  = bus.req_error[win_idx];
    assign bus.wb_ecause = ecause_a[win_idx];
    assign bus.wb_robid  = robid_a[win_idx];
    assign bus.wb_result = result_a[win_idx];
    assign bus.wb_grant  = win_idx;
`endif

endmodule
